// File: rtl/ef_psram_resp_pkg.sv
// Shared types and constants for the PSRAM responder.
package ef_psram_resp_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_RDATA,
        ST_WDATA
    } state_t;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_EQPI   = 8'h35;
    localparam logic [7:0] CMD_XQPI   = 8'hF5;

    // Commands whose address and data phases run 4 bits per sck
    function automatic logic is_quad_cmd(input logic [7:0] cmd);
        return (cmd == CMD_QREAD) || (cmd == CMD_QWRITE);
    endfunction

endpackage

// File: rtl/ef_psram_resp_mem.sv
// Single-port byte RAM with synchronous read and write enable.
module ef_psram_resp_mem #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Write port and registered read port share one address
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ef_psram_resp.sv
// PSRAM device-side responder (SPI/QSPI/QPI) serving an internal byte memory.
// Optional QPI command phase and 35h/F5h decode: define EF_PSRAM_RESP_QPI_EN.
module ef_psram_resp
    import ef_psram_resp_pkg::*;
#(
    parameter int unsigned MEM_AW     = 12,
    parameter int unsigned QREAD_WAIT = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic [3:0] douten,
    output logic       qpi_mode
);

    // [0]=first sync stage, [1]=synchronized, [2]=previous for edge detect
    logic [2:0]        r_sck_s;
    logic [1:0]        r_ce_s;
    logic [3:0]        r_din_s1;
    logic [3:0]        r_din_s2;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_sr;
    logic [7:0]        r_cmd;
    logic [MEM_AW-1:0] r_addr;
    logic [7:0]        r_obuf;
    logic              r_we;
    logic [7:0]        r_wbyte;
    logic [3:0]        r_dout;
    logic [3:0]        r_douten;
    logic              r_qpi;

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_ce_hi;
    logic              w_quad;
    logic [CNT_W-1:0]  w_step;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [ADDR_W-1:0] w_sr_nx;
    logic [7:0]        w_byte_nx;
    logic [7:0]        w_rdata;
    logic [7:0]        w_rbyte;

    // Two-stage synchronizers plus sck history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_s  <= '0;
            r_ce_s   <= '1;
            r_din_s1 <= '0;
            r_din_s2 <= '0;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], sck};
            r_ce_s   <= {r_ce_s[0], ce_n};
            r_din_s1 <= din;
            r_din_s2 <= r_din_s1;
        end
    end

    assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
    assign w_ce_hi    = r_ce_s[1];

    // Command phase width follows QPI mode; later phases follow the command
    assign w_quad    = (r_state == ST_CMD) ? r_qpi : is_quad_cmd(r_cmd);
    assign w_step    = w_quad ? CNT_W'(4) : CNT_W'(1);
    assign w_cnt_nx  = r_cnt + w_step;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_sr_nx   = w_quad ? {r_sr[ADDR_W-5:0], r_din_s2}
                              : {r_sr[ADDR_W-2:0], r_din_s2[0]};
    assign w_byte_nx = w_sr_nx[7:0];
    // First beat of each byte comes straight from the prefetched RAM word
    assign w_rbyte   = (r_cnt == '0) ? w_rdata : r_obuf;

    ef_psram_resp_mem #(
        .AW(MEM_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (r_we),
        .i_addr  (r_addr),
        .i_wdata (r_wbyte),
        .o_rdata (w_rdata)
    );

    // Protocol FSM with registered pin outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sr     <= '0;
            r_cmd    <= '0;
            r_addr   <= '0;
            r_obuf   <= '0;
            r_we     <= 1'b0;
            r_wbyte  <= '0;
            r_dout   <= '0;
            r_douten <= '0;
            r_qpi    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_we) begin
                r_addr <= r_addr + MEM_AW'(1);
            end
            if (w_ce_hi) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_dout   <= '0;
                r_douten <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_CMD;
                        r_cnt   <= '0;
                    end
                    ST_CMD: begin
                        // Stops consuming once 8 bits are in (mode switch or ignore)
                        if (w_sck_rise && (r_cnt < CNT_W'(8))) begin
                            r_sr  <= w_sr_nx;
                            r_cnt <= w_cnt_nx;
                            if (w_cnt_nx == CNT_W'(8)) begin
                                r_cmd <= w_byte_nx;
                                case (w_byte_nx)
                                    CMD_READ, CMD_WRITE, CMD_QREAD, CMD_QWRITE: begin
                                        r_state <= ST_ADDR;
                                        r_cnt   <= '0;
                                    end
`ifdef EF_PSRAM_RESP_QPI_EN
                                    CMD_EQPI: r_qpi <= 1'b1;
                                    CMD_XQPI: r_qpi <= 1'b0;
`endif
                                    default: ;
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sck_rise) begin
                            r_sr  <= w_sr_nx;
                            r_cnt <= w_cnt_nx;
                            if (w_cnt_nx == CNT_W'(ADDR_W)) begin
                                r_addr <= w_sr_nx[MEM_AW-1:0];
                                r_cnt  <= '0;
                                if (r_cmd == CMD_QREAD) begin
                                    r_state <= (QREAD_WAIT == 0) ? ST_RDATA : ST_WAIT;
                                end else if (r_cmd == CMD_READ) begin
                                    r_state <= ST_RDATA;
                                end else begin
                                    r_state <= ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (w_sck_rise) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_W'(QREAD_WAIT)) begin
                                r_state <= ST_RDATA;
                                r_cnt   <= '0;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_sck_fall) begin
                            r_cnt <= w_cnt_nx;
                            if (w_quad) begin
                                r_dout   <= w_rbyte[7:4];
                                r_obuf   <= {w_rbyte[3:0], 4'b0000};
                                r_douten <= 4'b1111;
                            end else begin
                                r_dout   <= {2'b00, w_rbyte[7], 1'b0};
                                r_obuf   <= {w_rbyte[6:0], 1'b0};
                                r_douten <= 4'b0010;
                            end
                            if (w_cnt_nx == CNT_W'(8)) begin
                                r_cnt  <= '0;
                                r_addr <= r_addr + MEM_AW'(1);
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_sck_rise) begin
                            r_sr  <= w_sr_nx;
                            r_cnt <= w_cnt_nx;
                            if (w_cnt_nx == CNT_W'(8)) begin
                                r_cnt   <= '0;
                                r_we    <= 1'b1;
                                r_wbyte <= w_byte_nx;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dout     = r_dout;
    assign douten   = r_douten;
    assign qpi_mode = r_qpi;

endmodule

// File: tb/tb_ef_psram_resp.sv
// Bench for ef_psram_resp: acts as the PSRAM controller and checks against a byte-array model.
module tb_ef_psram_resp;

    localparam int AW   = 12;
    localparam int MSZ  = 1 << AW;
    localparam int HP   = 5;

    logic       clk;
    logic       rst;
    logic       sck;
    logic       ce_n;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] douten;
    logic       qpi_mode;

    int         n_checks;
    int         n_errors;
    logic       tb_qpi;
    logic [7:0] mem_m [MSZ];
    logic [7:0] wbuf  [128];

    ef_psram_resp #(
        .MEM_AW     (12),
        .QREAD_WAIT (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .ce_n     (ce_n),
        .din      (din),
        .dout     (dout),
        .douten   (douten),
        .qpi_mode (qpi_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_lo();
        ce_n = 1'b0;
        tick(4);
    endtask

    // Deselect; outputs must be released within 3 clk of the pin rise
    task automatic cs_hi();
        ce_n = 1'b1;
        din  = 4'h0;
        tick(3);
        check("oe_release", 32'(douten), 32'h0);
        tick(3);
    endtask

    // One sck period: present d, sample the responder just before the rise
    task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        din = d;
        tick(HP);
        q   = dout;
        oe  = douten;
        sck = 1'b1;
        tick(HP);
        sck = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input int nbits, input logic quad);
        logic [3:0] q;
        logic [3:0] oe;
        int step;
        step = quad ? 4 : 1;
        for (int i = nbits - step; i >= 0; i -= step) begin
            if (quad) sck_cycle(v[i +: 4], q, oe);
            else      sck_cycle({3'b000, v[i]}, q, oe);
        end
    endtask

    // Receive one byte; oe_and/oe_or summarize douten over all its beats
    task automatic recv(input logic quad, output logic [7:0] b, output logic [7:0] oe_sum);
        logic [3:0] q;
        logic [3:0] oe;
        logic [3:0] oe_and;
        logic [3:0] oe_or;
        b      = '0;
        oe_and = 4'hF;
        oe_or  = 4'h0;
        for (int i = 0; i < (quad ? 2 : 8); i++) begin
            sck_cycle(4'h0, q, oe);
            oe_and &= oe;
            oe_or  |= oe;
            if (quad) b = {b[3:0], q};
            else      b = {b[6:0], q[1]};
        end
        oe_sum = {oe_and, oe_or};
    endtask

    task automatic do_write(input logic quad, input logic [23:0] a, input int n);
        cs_lo();
        send(32'(quad ? 8'h38 : 8'h02), 8, tb_qpi);
        send(32'(a), 24, quad);
        for (int i = 0; i < n; i++) begin
            send(32'(wbuf[i]), 8, quad);
            mem_m[(int'(a[11:0]) + i) % MSZ] = wbuf[i];
        end
        cs_hi();
    endtask

    task automatic do_read(input logic quad, input logic [23:0] a, input int n);
        logic [7:0] b;
        logic [7:0] oes;
        logic [3:0] q;
        logic [3:0] oe;
        int zeros;
        cs_lo();
        send(32'(quad ? 8'hEB : 8'h03), 8, tb_qpi);
        send(32'(a), 24, quad);
        if (quad) begin
            zeros = 0;
            for (int i = 0; i < 6; i++) begin
                sck_cycle(4'h0, q, oe);
                if (oe == 4'h0) zeros++;
            end
            check("qwait_oe_zero", 32'(zeros), 32'd6);
        end
        for (int i = 0; i < n; i++) begin
            recv(quad, b, oes);
            check(quad ? "qread_byte" : "read_byte", 32'(b),
                  32'(mem_m[(int'(a[11:0]) + i) % MSZ]));
            check(quad ? "qread_oe" : "read_oe", 32'(oes),
                  quad ? 32'hFF : 32'h22);
        end
        cs_hi();
    endtask

    initial begin
        logic [7:0]  b;
        logic [7:0]  oes;
        logic [31:0] r;
        logic [3:0]  q;
        logic [3:0]  oe;
        int          off;
        int          n;
        int          kind;
        logic [23:0] a;

        n_checks = 0;
        n_errors = 0;
        tb_qpi   = 1'b0;
        for (int i = 0; i < MSZ; i++) mem_m[i] = 8'h00;
        rst  = 1'b1;
        sck  = 1'b0;
        ce_n = 1'b1;
        din  = 4'h0;
        tick(4);
        rst = 1'b0;
        tick(2);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_douten", 32'(douten), 32'h0);
        check("rst_qpi", 32'(qpi_mode), 32'h0);

        // Preload a 96-byte window FF0h..04Fh (wraps through 000h)
        for (int i = 0; i < 96; i++) begin
            r = $urandom();
            wbuf[i] = r[7:0];
        end
        do_write(1'b1, 24'h000FF0, 96);

        // SPI write then read
        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h3C;
        do_write(1'b0, 24'h000010, 2);
        do_read(1'b0, 24'h000010, 2);

        // Quad read with dummy cycles
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        do_write(1'b0, 24'h000100, 4);
        do_read(1'b1, 24'h000100, 4);

        // Wrap-around at the top of memory
        for (int i = 0; i < 4; i++) begin
            r = $urandom();
            wbuf[i] = r[7:0];
        end
        do_write(1'b0, 24'h000FFE, 4);
        do_read(1'b0, 24'h000FFE, 2);
        do_read(1'b0, 24'h000000, 2);

        // Abort mid-byte: only the completed byte lands
        cs_lo();
        send(32'h02, 8, tb_qpi);
        send(32'h000020, 24, 1'b0);
        send(32'h5A, 8, 1'b0);
        send(32'h0F >> 3, 5, 1'b0);
        mem_m[32'h20] = 8'h5A;
        cs_hi();
        do_read(1'b0, 24'h000020, 2);

`ifdef EF_PSRAM_RESP_QPI_EN
        cs_lo();
        send(32'h35, 8, 1'b0);
        cs_hi();
        check("qpi_enter", 32'(qpi_mode), 32'h1);
        tb_qpi = 1'b1;
        wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
        do_write(1'b1, 24'h000030, 4);
        do_read(1'b1, 24'h000030, 4);
        cs_lo();
        send(32'hF5, 8, 1'b1);
        cs_hi();
        check("qpi_exit", 32'(qpi_mode), 32'h0);
        tb_qpi = 1'b0;
`else
        cs_lo();
        send(32'h35, 8, 1'b0);
        cs_hi();
        check("qpi_disabled", 32'(qpi_mode), 32'h0);
`endif

        // Reset during a read: outputs drop, memory survives
        cs_lo();
        send(32'h03, 8, 1'b0);
        send(32'h000010, 24, 1'b0);
        recv(1'b0, b, oes);
        check("pre_rst_byte", 32'(b), 32'(mem_m[32'h10]));
        for (int i = 0; i < 3; i++) sck_cycle(4'h0, q, oe);
        check("pre_rst_oe", 32'(oe), 32'h2);
        rst = 1'b1;
        tick(1);
        check("rst_mid_oe", 32'(douten), 32'h0);
        check("rst_mid_dout", 32'(dout), 32'h0);
        check("rst_mid_qpi", 32'(qpi_mode), 32'h0);
        rst  = 1'b0;
        ce_n = 1'b1;
        tick(6);
        do_read(1'b0, 24'h000010, 2);

        // Random traffic inside the known window, garbage in upper address bits
        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 3));
            off  = int'($urandom_range(0, 92));
            n    = int'($urandom_range(1, 4));
            r    = $urandom();
            a    = {r[11:0], 12'((32'hFF0 + 32'(off)) & 32'hFFF)};
            case (kind)
                0, 1: begin
                    for (int i = 0; i < n; i++) begin
                        r = $urandom();
                        wbuf[i] = r[7:0];
                    end
                    do_write(kind == 1, a, n);
                end
                default: do_read(kind == 3, a, n);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
